// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_t : controller states (IDLE, BUSY, DONE)
//   DIV_W   : default operand / quotient / remainder width
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division row.
//   p    : current partial remainder (WIDTH)
//   din  : next dividend bit shifted in
//   d    : divisor (WIDTH)
//   rem  : new partial remainder (WIDTH)
//   qbit : quotient bit produced by this row
// ----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] p,
    input  logic             din,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rem,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder always stays below the divisor (or is a pure
    // dividend prefix when d == 0), so a successful subtraction never sets
    // the top bit of trial; that bit is therefore a clean borrow flag.
    always_comb begin
        shifted = {p, din};
        trial   = shifted - {1'b0, d};
        qbit    = ~trial[WIDTH];
        rem     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/div4_seq_stream.sv
// ----------------------------------------------------------------------------
// div4_seq_stream
// Sequential unsigned restoring divider with valid/ready handshakes on both
// sides. One quotient bit per clock, MSB first; a result appears WIDTH
// edges after the accepting edge and is held until downstream takes it.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : dividend/divisor pair offered
//   in_ready  : block can accept a pair (IDLE only)
//   a, b      : dividend, divisor (unsigned, WIDTH bits)
//   out_valid : result held on q/r (DONE only)
//   out_ready : downstream accepts the result
//   q, r      : quotient, remainder (b == 0 gives q = all ones, r = a)
//   dbz       : divide-by-zero flag, present only when DIV4_ZERO_FLAG_EN
//               is defined; valid while out_valid is high
//
// Build option: define DIV4_ZERO_FLAG_EN to add the dbz port and register.
// ----------------------------------------------------------------------------
module div4_seq_stream
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
`ifdef DIV4_ZERO_FLAG_EN
    ,
    output logic             dbz
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
`ifdef DIV4_ZERO_FLAG_EN
    logic             dbz_reg;
`endif

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quo_next;

    // Single shared row, fed the dividend bit selected by the step counter.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p    (p_reg),
        .din  (a_reg[cnt_reg]),
        .d    (b_reg),
        .rem  (step_rem),
        .qbit (step_q)
    );

    assign quo_next = {quo_reg[WIDTH-2:0], step_q};

    // in_ready/out_valid are registered copies of "next state is IDLE/DONE".
    // After reset in_ready stays low until the first edge, and the
    // DONE->IDLE edge cannot also accept since in_ready is low in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            p_reg         <= '0;
            quo_reg       <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
`ifdef DIV4_ZERO_FLAG_EN
            dbz_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        p_reg        <= '0;
                        quo_reg      <= '0;
                        cnt_reg      <= CW'(WIDTH - 1);
                        state_reg    <= BUSY;
                        in_ready_reg <= 1'b0;
`ifdef DIV4_ZERO_FLAG_EN
                        dbz_reg      <= (b == '0);
`endif
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    p_reg   <= step_rem;
                    quo_reg <= quo_next;
                    if (cnt_reg == '0) begin
                        // q/r only change here, so an aborted run never
                        // exposes a partial result.
                        q_reg         <= quo_next;
                        r_reg         <= step_rem;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
`ifdef DIV4_ZERO_FLAG_EN
                        dbz_reg       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign q         = q_reg;
    assign r         = r_reg;
`ifdef DIV4_ZERO_FLAG_EN
    assign dbz       = dbz_reg;
`endif

endmodule : div4_seq_stream

// File: tb/tb_div4_seq_stream.sv
// ----------------------------------------------------------------------------
// tb_div4_seq_stream
// Directed and exhaustive checks of div4_seq_stream (WIDTH = 4) using a
// scoreboard queue: expected results are pushed on accept and popped when
// the DUT presents a result. Inputs are driven and outputs sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_div4_seq_stream;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic [W-1:0] r;
`ifdef DIV4_ZERO_FLAG_EN
    logic         dbz;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   nsent    = 0;
    int   nres     = 0;

    div4_seq_stream #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r)
`ifdef DIV4_ZERO_FLAG_EN
        ,
        .dbz       (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.a = av;
        e.b = bv;
        e.z = (bv == 0);
        if (bv == 0) begin
            e.q = 4'hF;
            e.r = av;
        end else begin
            e.q = av / bv;
            e.r = av % bv;
        end
        return e;
    endfunction

    // Enter at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit push, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        if (push) begin
            sb.push_back(model(av, bv));
            nsent++;
        end
        @(negedge clk);
        // Garbage while busy: must be ignored.
        in_valid  = 1'($urandom_range(0, 1));
        a         = W'($urandom);
        b         = W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
    endtask

    // Waits for the result, checks it, holds it for 'hold' cycles, consumes.
    task automatic recv(input string tag, input int hold);
        exp_t e;
        int   lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid !== 1'b1) begin
                in_valid  = 1'($urandom_range(0, 1));
                a         = W'($urandom);
                b         = W'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        out_ready = (hold == 0);
        check({tag, "_latency"}, lat, W);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
            e = model(0, 1);
        end else begin
            e = sb.pop_front();
        end
        nres++;
        check({tag, "_q"}, q, e.q);
        check({tag, "_r"}, r, e.r);
        check({tag, "_in_ready_done"}, in_ready, 0);
`ifdef DIV4_ZERO_FLAG_EN
        check({tag, "_dbz"}, dbz, e.z);
`endif
        if (e.b != 0) begin
            check({tag, "_identity"}, 32'(q) * 32'(e.b) + 32'(r), 32'(e.a));
            check({tag, "_r_lt_b"}, (r < e.b), 1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_q"}, q, e.q);
            check({tag, "_hold_r"}, r, e.r);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
`ifdef DIV4_ZERO_FLAG_EN
        check({tag, "_post_dbz"}, dbz, 0);
`endif
        out_ready = 1'b0;
        $display("txn %s a=%0d b=%0d q=%0d r=%0d lat=%0d hold=%0d", tag, e.a, e.b, e.q, e.r, lat, hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", in_ready, 0);
        @(negedge clk);
        check("rel_in_ready_first_edge", in_ready, 1);

        // Directed values
        send(4'd13, 4'd3, 1, 0);  recv("d13_3", 0);
        send(4'd15, 4'd1, 1, 0);  recv("d15_1", 0);
        send(4'd2,  4'd7, 1, 1);  recv("d2_7", 1);
        send(4'd7,  4'd0, 1, 0);  recv("d7_0", 0);
        send(4'd9,  4'd2, 1, 0);  recv("bp9_2", 5);

        // Reset in the second BUSY cycle: the run must vanish.
        send(4'd11, 4'd2, 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_q", q, 0);
        check("midrst_r", r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_result", out_valid, 0);
        end
        check("midrst_in_ready_after", in_ready, 1);
        check("midrst_q_after", q, 0);
        send(4'd12, 4'd5, 1, 0);  recv("d12_5", 0);

        // Exhaustive sweep with random gaps and backpressure
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                send(W'(ai), W'(bi), 1, $urandom_range(0, 2));
                recv("sweep", $urandom_range(0, 2));
            end
        end

        repeat (3) @(negedge clk);
        check("no_spurious_valid", out_valid, 0);
        check("sb_drained", sb.size(), 0);
        check("result_count", nres, nsent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div4_seq_stream

// File: doc/div4_seq_stream.md
DIV4_SEQ_STREAM -- requirements
Module: div4_seq_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand, quotient and remainder width; legal range 2..16.
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a pair.
REQ-006 SHALL have port a  input  WIDTH  dividend, unsigned.
REQ-007 SHALL have port b  input  WIDTH  divisor, unsigned.
REQ-008 SHALL have port out_valid  output  1  result held on q/r.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port q  output  WIDTH  quotient.
REQ-011 SHALL have port r  output  WIDTH  remainder.

Function
REQ-012 SHALL use a 3-state FSM: IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept = in_valid && in_ready at a clock edge; a and b SHALL be captured, partial remainder cleared, step counter loaded with WIDTH-1, and the FSM SHALL move IDLE->BUSY.
REQ-015 Each BUSY edge SHALL perform one restoring step, MSB first:
- form (WIDTH+1)-bit trial {P, a_reg[cnt]} - {0, b_reg};
- no borrow: P = trial[WIDTH-1:0], q bit = 1;
- borrow: P = shifted value, q bit = 0.
REQ-016 The BUSY edge with cnt == 0 SHALL move BUSY->DONE; otherwise cnt SHALL decrement.
REQ-017 out_valid SHALL rise exactly WIDTH edges after the accepting edge: 4 for the default.
REQ-018 In DONE, q, r and out_valid SHALL hold stable until out_ready = 1.
REQ-019 On that out_ready edge the FSM SHALL move DONE->IDLE.
REQ-020 No new pair SHALL be accepted in the DONE->IDLE cycle.
REQ-021 Sustained throughput SHALL be one result per WIDTH+2 cycles.
REQ-022 in_valid, a and b SHALL be ignored outside IDLE.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 b == 0 SHALL complete with normal latency, giving q = all ones and r = a; the block SHALL neither hang nor produce X.
REQ-025 q and r SHALL satisfy a == q*b + r and r < b for every b != 0.

Reset
REQ-026 rst_n low SHALL immediately force the FSM to IDLE, including mid-BUSY or mid-DONE.
REQ-027 Reset SHALL zero the counter, partial remainder, quotient, q and r.
REQ-028 During reset SHALL hold out_valid = 0 and in_ready = 0.
REQ-029 in_ready SHALL first go to 1 on the first edge after rst_n deasserts.
REQ-030 Any operation in flight at reset SHALL be discarded; no partial result SHALL appear on q or r.

Configuration
REQ-031 With macro DIV4_ZERO_FLAG_EN defined, the block SHALL add port dbz  output  1.
REQ-032 dbz SHALL latch (b == 0) at accept, be valid while out_valid = 1, reset to 0, and clear on return to IDLE.
REQ-033 Without DIV4_ZERO_FLAG_EN, port dbz and its register SHALL be absent; q and r behaviour SHALL be identical in both builds.

Structure
REQ-034 A shared package div_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the default-width constant DIV_W = 4.
REQ-035 Sub-module div_step SHALL be a combinational restoring row:
- inputs: partial remainder, next dividend bit, divisor;
- outputs: new remainder, quotient bit;
- instantiated once and reused every BUSY cycle.

Verification
REQ-036 a=13, b=3, out_ready=1: out_valid 4 edges after accept, with q=4, r=1.
REQ-037 a=15, b=1 -> q=15, r=0; a=2, b=7 -> q=0, r=2.
REQ-038 a=7, b=0 -> q=15, r=7, no hang; with DIV4_ZERO_FLAG_EN, dbz=1.
REQ-039 Backpressure: result 9/2 with out_ready=0 for 5 cycles -> q=4, r=1 held stable, in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-040 Reset pulse in the 2nd BUSY cycle: out_valid stays 0, q=r=0, in_ready=1 after release; the following 12/5 -> q=2, r=2.
REQ-041 Exhaustive sweep of all 256 (a, b) pairs with random in_valid/out_ready gaps: every result obeys REQ-024/REQ-025, and no pair is dropped or duplicated.
